// File: rtl/barker_corr_stream.sv
// barker_corr_stream: streaming correlator of signed soft samples against a +/-1 code, with peak flags.
// Define BARKER_CORR_ABS_EN to also flag inverted-polarity peaks on m_tuser[1].
module barker_corr_stream #(
    parameter int          CODE_LEN = 11,
    parameter logic [12:0] CODE     = 13'b0011100010010,
    parameter int          DATA_W   = 8,
    parameter int          THRESH   = 512,
    localparam int         CORR_W   = DATA_W + $clog2(CODE_LEN + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic signed [CORR_W-1:0] m_tdata,
    output logic [1:0]               m_tuser,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [15:0]              o_peak_cnt
);

    localparam int FILL_W = $clog2(CODE_LEN + 1);
    localparam logic [FILL_W-1:0]        FILL_FULL  = FILL_W'(CODE_LEN);
    localparam logic signed [CORR_W-1:0] THRESH_POS = CORR_W'(THRESH);
`ifdef BARKER_CORR_ABS_EN
    localparam logic signed [CORR_W-1:0] THRESH_NEG = -THRESH_POS;
`endif

    function automatic logic signed [CORR_W-1:0] widen(input logic signed [DATA_W-1:0] x);
        return {{(CORR_W - DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    logic signed [DATA_W-1:0] window_q  [CODE_LEN];
    logic signed [DATA_W-1:0] window_d  [CODE_LEN];
    logic signed [DATA_W-1:0] win_shift [CODE_LEN];
    logic [FILL_W-1:0]        fill_q, fill_d, fill_post;
    logic signed [CORR_W-1:0] corr;
    logic [1:0]               peak_flags;
    logic                     accept, load;

    logic                     m_tvalid_q, m_tvalid_d;
    logic signed [CORR_W-1:0] m_tdata_q, m_tdata_d;
    logic [1:0]               m_tuser_q, m_tuser_d;
    logic                     m_tlast_q, m_tlast_d;
    logic [15:0]              peak_cnt_q, peak_cnt_d;

    // The register can take a new result whenever it is empty or being drained this cycle.
    assign s_tready = ~m_tvalid_q | m_tready;
    assign accept   = s_tvalid & s_tready;

    always_comb begin
        win_shift[0] = s_tdata;
        for (int i = 1; i < CODE_LEN; i++) begin
            win_shift[i] = window_q[i-1];
        end
    end

    // Correlation is taken over the post-shift window so the result belongs to this sample.
    always_comb begin
        corr = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (CODE[i]) begin
                corr = corr + widen(win_shift[i]);
            end else begin
                corr = corr - widen(win_shift[i]);
            end
        end
    end

    always_comb begin
        peak_flags    = 2'b00;
        peak_flags[0] = (corr >= THRESH_POS);
`ifdef BARKER_CORR_ABS_EN
        peak_flags[1] = (corr <= THRESH_NEG);
`endif
    end

    always_comb begin
        fill_post = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        load      = accept && (fill_post == FILL_FULL);

        fill_d = fill_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            window_d[i] = window_q[i];
        end
        if (accept) begin
            // End of frame wipes history after this sample's result has been formed.
            if (s_tlast) begin
                fill_d = '0;
                for (int i = 0; i < CODE_LEN; i++) begin
                    window_d[i] = '0;
                end
            end else begin
                fill_d = fill_post;
                for (int i = 0; i < CODE_LEN; i++) begin
                    window_d[i] = win_shift[i];
                end
            end
        end
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        peak_cnt_d = peak_cnt_q;
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = corr;
            m_tuser_d  = peak_flags;
            m_tlast_d  = s_tlast;
            if (peak_flags != 2'b00) begin
                peak_cnt_d = sat_inc16(peak_cnt_q);
            end
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                window_q[i] <= '0;
            end
            fill_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= 2'b00;
            m_tlast_q  <= 1'b0;
            peak_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < CODE_LEN; i++) begin
                window_q[i] <= window_d[i];
            end
            fill_q     <= fill_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
            peak_cnt_q <= peak_cnt_d;
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tuser    = m_tuser_q;
    assign m_tlast    = m_tlast_q;
    assign o_peak_cnt = peak_cnt_q;

endmodule
